// File: rtl/iser_pkg.sv
// Shared definitions for the FCO frame aligner.
//   fco_state_e      : aligner state machine encoding (SEARCH, VERIFY, LOCKED)
//   FRAME_CYC_16B/12B: data_clk cycles per frame for each frame length
//   POS_BOUNDARY/MID : encodings of the frame-edge phase inside a nibble
//   frame_last()     : last cycle index of a frame for the selected length
package iser_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } fco_state_e;

  localparam int unsigned FRAME_CYC_16B = 4;
  localparam int unsigned FRAME_CYC_12B = 3;

  localparam logic POS_BOUNDARY = 1'b0;  // rising edge on a nibble boundary
  localparam logic POS_MID      = 1'b1;  // rising edge between the two nibble bits

  // Index of the final cycle of a frame; the cycle counter wraps after it.
  function automatic logic [1:0] frame_last(input logic sel_12b);
    return sel_12b ? 2'(FRAME_CYC_12B - 1) : 2'(FRAME_CYC_16B - 1);
  endfunction

endpackage

// File: rtl/iser_fco_align_if.sv
// Bundle of the aligner's FCO input and frame-timing outputs.
//   fco_nib      : FCO lane nibble, bit[1] earlier in time
//   sel_num_bits : 0 = 16-bit frame, 1 = 12-bit frame (quasi-static)
//   fco_strobe   : one-cycle pulse at each frame start
//   fco_position : edge phase for the current lock, held between strobes
//   fco_locked   : aligner is in LOCKED
//   fco_err_cnt  : saturating count of bad frames seen while locked
//   dbg_state    : current aligner state, for observation only
// Handshake: there is no valid/ready backpressure. fco_nib is consumed on
// every data_clk edge; fco_strobe is a single-cycle qualifier that marks the
// frame start and needs no acknowledge.
interface iser_fco_align_if #(
  parameter int ERR_CNT_W = 8
);
  import iser_pkg::*;

  logic [1:0]           fco_nib;
  logic                 sel_num_bits;
  logic                 fco_strobe;
  logic                 fco_position;
  logic                 fco_locked;
  logic [ERR_CNT_W-1:0] fco_err_cnt;
  fco_state_e           dbg_state;

  modport master (
    output fco_nib, sel_num_bits,
    input  fco_strobe, fco_position, fco_locked, fco_err_cnt, dbg_state
  );

  modport slave (
    input  fco_nib, sel_num_bits,
    output fco_strobe, fco_position, fco_locked, fco_err_cnt, dbg_state
  );

endinterface

// File: rtl/iser_fco_edge_det.sv
// Registers the FCO nibble stream and flags the frame-start rising edge on
// the registered (previous, current) nibble pair.
//   data_clk, rst_n : clock and asynchronous active-low reset
//   fco_nib         : raw FCO nibble, bit[1] earlier in time
//   fco_edge        : rising edge found in the current registered nibble
//   fco_edge_pos    : POS_BOUNDARY or POS_MID, valid while fco_edge is high
module iser_fco_edge_det
  import iser_pkg::*;
(
  input  logic       data_clk,
  input  logic       rst_n,
  input  logic [1:0] fco_nib,
  output logic       fco_edge,
  output logic       fco_edge_pos
);

  logic [1:0] nib_q, nib_d;
  logic [1:0] prev_q, prev_d;

  always_comb begin
    nib_d  = fco_nib;
    prev_d = nib_q;
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q  <= 2'b00;
      prev_q <= 2'b00;
    end else begin
      nib_q  <= nib_d;
      prev_q <= prev_d;
    end
  end

  // Boundary edge: last bit of the previous nibble low, both current bits
  // high. Mid edge: the current nibble itself goes 0 -> 1.
  always_comb begin
    fco_edge     = 1'b0;
    fco_edge_pos = POS_BOUNDARY;
    if (!prev_q[0] && (nib_q == 2'b11)) begin
      fco_edge     = 1'b1;
      fco_edge_pos = POS_BOUNDARY;
    end else if (!nib_q[1] && nib_q[0]) begin
      fco_edge     = 1'b1;
      fco_edge_pos = POS_MID;
    end
  end

endmodule

// File: rtl/iser_fco_align.sv
// FCO frame aligner. Finds the frame-start rising edge on the deserialized
// FCO lane, verifies it repeats with a constant phase, then flywheels a
// per-frame strobe while counting frames that miss the expected edge.
//   data_clk, rst_n : clock and asynchronous active-low reset
//   bus (slave)     : fco_nib / sel_num_bits in; fco_strobe, fco_position,
//                     fco_locked, fco_err_cnt, dbg_state out
module iser_fco_align
  import iser_pkg::*;
#(
  parameter int LOCK_FRAMES = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic              data_clk,
  input  logic              rst_n,
  iser_fco_align_if.slave   bus
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  fco_state_e           state_q, state_d;
  logic [1:0]           cyc_q, cyc_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [BAD_W-1:0]     bad_run_q, bad_run_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 pos_ref_q, pos_ref_d;
  logic                 pos_out_q, pos_out_d;
  logic                 strobe_q, strobe_d;
  logic                 frame_bad_q, frame_bad_d;
  logic                 sel_q, sel_d;
  logic                 sel_prev_q, sel_prev_d;

  logic                 fco_edge;
  logic                 fco_edge_pos;
  logic                 sel_chg;
  logic                 wrap;
  logic                 edge_ok;
  logic [GOOD_W-1:0]    good_inc;
  logic [BAD_W-1:0]     bad_inc;

  iser_fco_edge_det u_edge_det (
    .data_clk     (data_clk),
    .rst_n        (rst_n),
    .fco_nib      (bus.fco_nib),
    .fco_edge     (fco_edge),
    .fco_edge_pos (fco_edge_pos)
  );

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      cyc_q       <= 2'd0;
      good_q      <= '0;
      bad_run_q   <= '0;
      err_q       <= '0;
      pos_ref_q   <= POS_BOUNDARY;
      pos_out_q   <= POS_BOUNDARY;
      strobe_q    <= 1'b0;
      frame_bad_q <= 1'b0;
      sel_q       <= 1'b0;
      sel_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      good_q      <= good_d;
      bad_run_q   <= bad_run_d;
      err_q       <= err_d;
      pos_ref_q   <= pos_ref_d;
      pos_out_q   <= pos_out_d;
      strobe_q    <= strobe_d;
      frame_bad_q <= frame_bad_d;
      sel_q       <= sel_d;
      sel_prev_q  <= sel_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    good_d      = good_q;
    bad_run_d   = bad_run_q;
    err_d       = err_q;
    pos_ref_d   = pos_ref_q;
    pos_out_d   = pos_out_q;
    strobe_d    = 1'b0;
    frame_bad_d = frame_bad_q;
    sel_d       = bus.sel_num_bits;
    sel_prev_d  = sel_q;

    // The frame length in use is the registered select, aligned with the
    // registered nibble that the edge detector looks at.
    sel_chg  = (sel_q != sel_prev_q);
    wrap     = (cyc_q == frame_last(sel_q));
    edge_ok  = fco_edge && (fco_edge_pos == pos_ref_q);
    good_inc = good_q + 1'b1;
    bad_inc  = bad_run_q + 1'b1;

    if (state_q != SEARCH) begin
      cyc_d = wrap ? 2'd0 : cyc_q + 2'd1;
    end

    if (sel_chg) begin
      // A frame-length change invalidates any timing learnt so far.
      state_d     = SEARCH;
      cyc_d       = 2'd0;
      good_d      = '0;
      bad_run_d   = '0;
      frame_bad_d = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          cyc_d       = 2'd0;
          frame_bad_d = 1'b0;
          if (fco_edge) begin
            pos_ref_d = fco_edge_pos;
            good_d    = '0;
            state_d   = VERIFY;
          end
        end
        VERIFY: begin
          if (wrap) begin
            if (edge_ok) begin
              good_d = good_inc;
              if (good_inc == GOOD_W'(LOCK_FRAMES - 1)) begin
                state_d     = LOCKED;
                pos_out_d   = pos_ref_q;
                bad_run_d   = '0;
                frame_bad_d = 1'b0;
              end
            end else begin
              state_d = SEARCH;
            end
          end else if (fco_edge) begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: the strobe follows the counter, not the observed edge.
          // An edge off the wrap cycle marks the frame bad; the verdict is
          // taken once per frame, at the wrap.
          if (wrap) begin
            strobe_d    = 1'b1;
            frame_bad_d = 1'b0;
            if (frame_bad_q || !edge_ok) begin
              bad_run_d = bad_inc;
              if (err_q != '1) begin
                err_d = err_q + 1'b1;
              end
              if (bad_inc == BAD_W'(UNLOCK_ERRS)) begin
                state_d = SEARCH;
              end
            end else begin
              bad_run_d = '0;
            end
          end else if (fco_edge) begin
            frame_bad_d = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  assign bus.fco_strobe   = strobe_q;
  assign bus.fco_position = pos_out_q;
  assign bus.fco_locked   = (state_q == LOCKED);
  assign bus.fco_err_cnt  = err_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_iser_fco_align.sv
module tb_iser_fco_align;

  localparam int LOCK_FRAMES = 8;
  localparam int UNLOCK_ERRS = 4;
  localparam int ERR_MAX     = 255;
  localparam int EXP_W       = 11;  // {strobe, locked, position, err_cnt[7:0]}

  localparam logic [7:0] P16_POS0 = 8'b11_11_00_00;
  localparam logic [7:0] P16_POS1 = 8'b01_11_10_00;
  localparam logic [7:0] P12_POS0 = 8'b11_10_00_00;
  localparam logic [7:0] P12_POS1 = 8'b01_11_00_00;

  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  // ---------------- clock / reset ----------------
  logic data_clk;
  logic rst_n;

  initial data_clk = 1'b0;
  always #5 data_clk = ~data_clk;

  iser_fco_align_if #(.ERR_CNT_W(8)) bus ();

  iser_fco_align #(
    .LOCK_FRAMES (LOCK_FRAMES),
    .UNLOCK_ERRS (UNLOCK_ERRS),
    .ERR_CNT_W   (8)
  ) dut (
    .data_clk (data_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs, one entry per sampled nibble; each entry becomes
  // visible on the DUT outputs one clock after the nibble is sampled.
  logic [EXP_W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Works on absolute time: frame starts are the cycles whose distance from
  // the anchoring edge is a multiple of the frame length.
  int         m_state, m_t, m_anchor, m_good, m_bad_run, m_err;
  logic       m_ref, m_pos, m_stray, m_prev_sel;
  logic [1:0] m_prev_nib;

  task automatic model_reset();
    m_state = M_SEARCH; m_t = 0; m_anchor = 0; m_good = 0; m_bad_run = 0;
    m_err = 0; m_ref = 0; m_pos = 0; m_stray = 0; m_prev_sel = 0;
    m_prev_nib = 2'b00;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic ref_cycle(input logic [1:0] nib, input logic sel);
    logic rise_b, rise_m, ev, p, wrap, stb;
    int fr;
    rise_b = (m_prev_nib[0] == 1'b0) && (nib == 2'b11);
    rise_m = (nib[1] == 1'b0) && (nib[0] == 1'b1);
    ev     = rise_b || rise_m;
    p      = rise_m;
    fr     = sel ? 3 : 4;
    wrap   = (m_t != m_anchor) && (((m_t - m_anchor) % fr) == 0);
    stb    = 1'b0;
    if (sel != m_prev_sel) begin
      m_state = M_SEARCH;
    end else if (m_state == M_SEARCH) begin
      if (ev) begin
        m_state = M_VERIFY; m_anchor = m_t; m_ref = p; m_good = 0;
      end
    end else if (m_state == M_VERIFY) begin
      if (wrap && ev && (p == m_ref)) begin
        m_good++;
        if (m_good == LOCK_FRAMES - 1) begin
          m_state = M_LOCKED; m_pos = m_ref; m_bad_run = 0; m_stray = 0;
        end
      end else if (wrap || ev) begin
        m_state = M_SEARCH;
      end
    end else begin
      if (wrap) begin
        stb = 1'b1;
        if (m_stray || !(ev && (p == m_ref))) begin
          m_bad_run++;
          if (m_err < ERR_MAX) m_err++;
          if (m_bad_run == UNLOCK_ERRS) m_state = M_SEARCH;
        end else begin
          m_bad_run = 0;
        end
        m_stray = 1'b0;
      end else if (ev) begin
        m_stray = 1'b1;
      end
    end
    m_prev_nib = nib;
    m_prev_sel = sel;
    m_t++;
    exp_q.push_back({stb, (m_state == M_LOCKED), m_pos, 8'(m_err)});
  endtask

  // ---------------- driver ----------------
  function automatic logic [1:0] pat_nib(input logic [7:0] pat, input int c);
    return pat[7 - 2 * c -: 2];
  endfunction

  function automatic logic [EXP_W-1:0] dut_obs();
    return {bus.fco_strobe, bus.fco_locked, bus.fco_position, bus.fco_err_cnt};
  endfunction

  // Called at a falling edge: drive, let the DUT sample, return at the next
  // falling edge where outputs are stable.
  task automatic step(input logic [1:0] nib, input logic sel);
    bus.fco_nib      = nib;
    bus.sel_num_bits = sel;
    @(posedge data_clk);
    ref_cycle(nib, sel);
    @(negedge data_clk);
  endtask

  task automatic do_reset(input logic sel);
    rst_n            = 1'b0;
    bus.fco_nib      = 2'b00;
    bus.sel_num_bits = sel;
    repeat (3) @(negedge data_clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EXP_W-1:0] obs, exp;
    rst_n = 1'b0; bus.fco_nib = 2'b11; bus.sel_num_bits = 1'b1;
    repeat (3) @(negedge data_clk);
    n_checks++; if (bus.fco_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got=%b want=0", bus.fco_strobe); end
    n_checks++; if (bus.fco_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b want=0", bus.fco_locked); end
    n_checks++; if (bus.fco_position !== 1'b0) begin n_fail++; $display("FAIL reset_position got=%b want=0", bus.fco_position); end
    n_checks++; if (bus.fco_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d want=0", bus.fco_err_cnt); end
    model_reset();
    bus.fco_nib = 2'b00; bus.sel_num_bits = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b0);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_idle i=%0d got=%b want=%b", i, obs, exp); end
    end
  endtask

  task automatic test_lock(input logic [7:0] pat, input logic sel, input logic exp_pos, input string name);
    logic [EXP_W-1:0] obs, exp;
    int fr, pre, n, lock_at, strobes, lock_nib;
    fr = sel ? 3 : 4;
    pre = $urandom_range(1, 4);
    n = pre + 12 * fr;
    do_reset(sel);
    lock_at = -1; strobes = 0;
    for (int i = 0; i < n; i++) begin
      step((i < pre) ? 2'b00 : pat_nib(pat, (i - pre) % fr), sel);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s i=%0d got=%b want=%b", name, i, obs, exp); end
      if (bus.fco_locked === 1'b1 && lock_at < 0) lock_at = i;
      if (bus.fco_strobe === 1'b1) strobes++;
    end
    // First edge at nibble pre, lock decided LOCK_FRAMES-1 frames later,
    // visible one step after that decision.
    lock_nib = pre + (LOCK_FRAMES - 1) * fr;
    n_checks++; if (lock_at != lock_nib + 1) begin n_fail++; $display("FAIL %s_lock_time got=%0d want=%0d", name, lock_at, lock_nib + 1); end
    n_checks++; if (strobes != (n - 2 - lock_nib) / fr) begin n_fail++; $display("FAIL %s_strobe_count got=%0d want=%0d", name, strobes, (n - 2 - lock_nib) / fr); end
    n_checks++; if (bus.fco_position !== exp_pos) begin n_fail++; $display("FAIL %s_position got=%b want=%b", name, bus.fco_position, exp_pos); end
  endtask

  task automatic test_single_bad_frame();
    logic [EXP_W-1:0] obs, exp;
    int pre, bad_f;
    pre = $urandom_range(1, 4);
    bad_f = $urandom_range(12, 14);
    do_reset(1'b0);
    for (int i = 0; i < pre + 18 * 4; i++) begin
      step((i < pre || (i - pre) / 4 == bad_f) ? 2'b00 : pat_nib(P16_POS0, (i - pre) % 4), 1'b0);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL single_bad i=%0d got=%b want=%b", i, obs, exp); end
    end
    n_checks++; if (bus.fco_err_cnt !== 8'd1) begin n_fail++; $display("FAIL single_bad_err_cnt got=%0d want=1", bus.fco_err_cnt); end
    n_checks++; if (bus.fco_locked !== 1'b1) begin n_fail++; $display("FAIL single_bad_locked got=%b want=1", bus.fco_locked); end
  endtask

  task automatic test_unlock_relock();
    logic [EXP_W-1:0] obs, exp;
    int pre;
    pre = $urandom_range(1, 4);
    do_reset(1'b0);
    for (int i = 0; i < pre + 16 * 4; i++) begin
      step((i < pre || i >= pre + 12 * 4) ? 2'b00 : pat_nib(P16_POS0, (i - pre) % 4), 1'b0);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL unlock i=%0d got=%b want=%b", i, obs, exp); end
    end
    n_checks++; if (bus.fco_locked !== 1'b0) begin n_fail++; $display("FAIL unlock_locked got=%b want=0", bus.fco_locked); end
    n_checks++; if (bus.fco_err_cnt !== 8'd4) begin n_fail++; $display("FAIL unlock_err_cnt got=%0d want=4", bus.fco_err_cnt); end
    for (int i = 0; i < 12 * 4; i++) begin
      step(pat_nib(P16_POS0, i % 4), 1'b0);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL relock i=%0d got=%b want=%b", i, obs, exp); end
    end
    n_checks++; if (bus.fco_locked !== 1'b1) begin n_fail++; $display("FAIL relock_locked got=%b want=1", bus.fco_locked); end
    n_checks++; if (bus.fco_err_cnt !== 8'd4) begin n_fail++; $display("FAIL relock_err_cnt got=%0d want=4", bus.fco_err_cnt); end
  endtask

  task automatic test_sel_change();
    logic [EXP_W-1:0] obs, exp;
    int pre;
    pre = $urandom_range(1, 4);
    do_reset(1'b0);
    for (int i = 0; i < pre + 12 * 4; i++) begin
      step((i < pre) ? 2'b00 : pat_nib(P16_POS0, (i - pre) % 4), 1'b0);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL sel_pre i=%0d got=%b want=%b", i, obs, exp); end
    end
    n_checks++; if (bus.fco_locked !== 1'b1) begin n_fail++; $display("FAIL sel_locked_before got=%b want=1", bus.fco_locked); end
    for (int i = 0; i < 14 * 3; i++) begin
      step(pat_nib(P12_POS1, i % 3), 1'b1);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL sel_post i=%0d got=%b want=%b", i, obs, exp); end
      if (i == 1) begin
        n_checks++; if (bus.fco_locked !== 1'b0) begin n_fail++; $display("FAIL sel_unlock got=%b want=0", bus.fco_locked); end
      end
    end
    n_checks++; if (bus.fco_locked !== 1'b1) begin n_fail++; $display("FAIL sel_relock got=%b want=1", bus.fco_locked); end
    n_checks++; if (bus.fco_position !== 1'b1) begin n_fail++; $display("FAIL sel_position got=%b want=1", bus.fco_position); end
  endtask

  task automatic test_random_noise();
    logic [EXP_W-1:0] obs, exp;
    logic sel;
    logic [7:0] pat;
    int fr;
    sel = 1'($urandom_range(0, 1));
    pat = sel ? P12_POS0 : P16_POS1;
    fr = sel ? 3 : 4;
    do_reset(sel);
    for (int i = 0; i < 400; i++) begin
      // Mostly a clean pattern with sparse corruption, then pure noise.
      if (i < 340 && $urandom_range(0, 11) != 0) step(pat_nib(pat, i % fr), sel);
      else step(2'($urandom_range(0, 3)), sel);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL noise i=%0d got=%b want=%b", i, obs, exp); end
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [EXP_W-1:0] obs, exp;
    int pre;
    pre = $urandom_range(1, 4);
    do_reset(1'b0);
    for (int i = 0; i < pre + 12 * 4 + $urandom_range(0, 3); i++) begin
      step((i < pre) ? 2'b00 : pat_nib(P16_POS1, (i - pre) % 4), 1'b0);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL midrst_pre i=%0d got=%b want=%b", i, obs, exp); end
    end
    n_checks++; if (bus.fco_position !== 1'b1) begin n_fail++; $display("FAIL midrst_pos_before got=%b want=1", bus.fco_position); end
    @(posedge data_clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dut_obs() !== '0) begin n_fail++; $display("FAIL midrst_async got=%b want=0", dut_obs()); end
    @(negedge data_clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(pat_nib(P16_POS1, i % 4), 1'b0);
      exp = exp_q.pop_front(); obs = dut_obs(); n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL midrst_post i=%0d got=%b want=%b", i, obs, exp); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fco_nib = 2'b00;
    bus.sel_num_bits = 1'b0;
    model_reset();
    test_reset();
    test_lock(P16_POS0, 1'b0, 1'b0, "lock16_pos0");
    test_lock(P16_POS1, 1'b0, 1'b1, "lock16_pos1");
    test_lock(P12_POS0, 1'b1, 1'b0, "lock12_pos0");
    test_lock(P12_POS1, 1'b1, 1'b1, "lock12_pos1");
    test_single_bad_frame();
    test_unlock_relock();
    test_sel_change();
    test_random_noise();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
